// File: rtl/sevseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with double-buffered,
// frame-synchronous pattern commit. Define SEVSEG_DIM_EN to add PWM dimming.
module sevseg_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 4,
  parameter int DIV_W    = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
`ifdef SEVSEG_DIM_EN
  input  logic [2:0] brightness,
`endif
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  typedef enum logic {BLANK, ON} phase_t;

  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_C = DIV_W'(GUARD);

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [1:0]       slot;
  logic             pending;
  logic [7:0]       shadow [4];
  logic [7:0]       active [4];
  phase_t           phase, phase_nxt;
  logic             tc, boundary, dim_on;
  logic [7:0]       seg_nxt;
  logic [3:0]       an_nxt;

`ifdef SEVSEG_DIM_EN
  logic [2:0] pwm;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm + 3'd1;
  end

  assign dim_on = (pwm <= brightness);
`else
  assign dim_on = 1'b1;
`endif

  assign wr_ready = !pending;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    tc        = (cnt == CNT_MAX);
    cnt_nxt   = tc ? '0 : cnt + DIV_W'(1);
    phase_nxt = (cnt_nxt < GUARD_C) ? BLANK : ON;
    boundary  = tc && (slot == 2'd3);
    seg_nxt   = 8'hFF;
    an_nxt    = 4'hF;
    if (phase == ON) begin
      seg_nxt = active[slot];
      if (dim_on) an_nxt = ~(4'b0001 << slot);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) phase <= BLANK;
    else        phase <= phase_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      slot       <= 2'd0;
      pending    <= 1'b0;
      seg        <= 8'hFF;
      an         <= 4'hF;
      frame_done <= 1'b0;
      // NOTE: the pattern buffers are reset because blank must be shown after reset.
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 8'hFF;
        active[i] <= 8'hFF;
      end
    end else begin
      cnt        <= cnt_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= boundary;
      if (tc) slot <= slot + 2'd1;

      // Commit uses the pre-edge shadow, so a write on the boundary edge waits a frame.
      if (boundary && pending) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow[i];
        pending <= 1'b0;
      end

      if (wr_valid && wr_ready) begin
        shadow[wr_digit] <= wr_data;
        if (wr_last) pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sevseg_scan_ctrl.md
# sevseg_scan_ctrl

Scan controller for the 4-digit multiplexed seven-segment display. Holds a double-buffered set of four raw segment patterns (active-low, 8 bits incl. DP) that requesters write over a valid/ready port. It sequences the anodes at a prescaled refresh rate with an anti-ghosting blank guard per digit, and commits new patterns only on frame boundaries so the display never tears. It drives `seg`/`an` on the board pins directly.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot; must be greater than `GUARD`.
- `GUARD`, 4: blank cycles at the start of each slot, during which all anodes are off.
- `DIV_W`, 17: prescaler width; 2^DIV_W ≥ SCAN_DIV.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_digit` in 2: target digit, 0 = rightmost (`an[0]`).
- `wr_data` in 8: raw active-low segment pattern.
- `wr_last` in 1: final write of an update; requests a commit.
- `brightness` in 3: dimming level; present only with `SEVSEG_DIM_EN`.
- `seg` out 8: active-low segments, registered.
- `an` out 4: active-low anodes, registered, one-hot-low or all-high.
- `frame_done` out 1: 1-cycle pulse after each frame boundary.

## Operation
- Storage:
  - `shadow[0..3]` receives writes.
  - `active[0..3]` feeds the display.
  - All entries reset to 8'hFF (blank).
- Prescaler `cnt` runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and `slot` advances 0→1→2→3→0. `slot` wraps mod 4.
- Phase FSM, per slot:
  - BLANK while `cnt < GUARD`: `an`=4'hF, `seg`=8'hFF.
  - ON while `cnt ≥ GUARD`: `an` = ~(1<<slot), `seg` = `active[slot]`.
- Frame boundary is the edge on which `slot`=3 and `cnt`=SCAN_DIV-1.
- Write handshake:
  - Accepted write: `shadow[wr_digit]` <= `wr_data`.
  - Accepted write with `wr_last`=1: `pending` <= 1, and `wr_ready` is 0 from the next cycle.
  - Writes to the same digit before commit overwrite each other.
- Commit: at the frame boundary, if `pending`=1, all four entries `active` <= `shadow`, `pending` <= 0, and `wr_ready` is 1 from the next cycle.
  - A `wr_last` write accepted on the boundary edge itself is not committed by that boundary; it sets `pending` and commits at the next boundary.
- `wr_ready` = !`pending`. It is independent of `wr_valid`.
- `frame_done` pulses on every frame boundary, whether or not a commit occurred.
- Reset mid-operation: the next edge with `rst_n`=0 clears everything to reset values. Pending data is discarded.

## Timing
- Reset values:
  - `seg`=8'hFF, `an`=4'hF, `wr_ready`=1, `frame_done`=0.
  - `cnt`=0, `slot`=0, `pending`=0, buffers 8'hFF.
- Outputs are registered and reflect the `cnt`/`slot` state of the previous cycle.
  - First edge after reset release: `seg`/`an` show BLANK.
  - Slot 0 anode goes low GUARD+1 edges after release.
- Each anode is low for SCAN_DIV-GUARD cycles per frame. Frame period is 4·SCAN_DIV cycles.
- Write-to-visible latency: at most 4·SCAN_DIV + GUARD + 1 cycles after the commit boundary following `wr_last` acceptance.
- Write throughput: one write per cycle while `wr_ready`=1.

## Configuration
- `SEVSEG_DIM_EN` defined:
  - The `brightness` port exists.
  - A free-running 3-bit `pwm` counter increments every cycle and resets to 0.
  - During ON, `an` is driven as in ON only when `pwm ≤ brightness`; otherwise `an`=4'hF.
  - `seg` is unaffected.
  - `brightness`=7 is identical to the non-dimmed behaviour.
- `SEVSEG_DIM_EN` undefined: no port and no counter; ON is always fully driven.

## Test plan
All scenarios use SCAN_DIV=8, GUARD=2 (frame = 32 cycles).
- Reset, then 40 idle cycles:
  - `an` sequence per slot is 1111×2 then 1110×6, 1111×2, 1101×6, …, 0111×6.
  - `seg` is 8'hFF throughout.
  - `frame_done` pulses once at cycle 32.
- Write digits 0..3 = 8'hC0, 8'hF9, 8'hA4, 8'hB0 with `wr_last` on the fourth:
  - `wr_ready` drops the next cycle.
  - No change before the boundary.
  - After the boundary, the slot k ON phase shows its pattern; `wr_ready` returns to 1 the cycle after the boundary.
- Hold `wr_valid`=1 while `pending`=1: no acceptance and no shadow change; the committed frame equals the pre-`pending` data.
- `wr_last` write accepted exactly on the boundary edge: not visible in the following frame; visible after the next boundary.
- Assert `rst_n`=0 for one cycle mid-slot 2 with a write pending:
  - Next cycle `an`=4'hF, `seg`=8'hFF, `wr_ready`=1.
  - Scan restarts at slot 0 and shows blanks.
- With `SEVSEG_DIM_EN`, `brightness`=1: during ON phases the anode is low exactly when `pwm`∈{0,1}, i.e. 2 of every 8 cycles.
